// File: rtl/cy_tdm_demux8.sv
// Receive-side TDM demultiplexer: rebuilds CHANNELS parallel bits from a
// serial stream framed by a slot-0 sync marker and presents one registered
// word per complete frame.
module cy_tdm_demux8 #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned SEL_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 d,
    input  logic                 sync,
    output logic [CHANNELS-1:0]  y,
    output logic                 frame_valid,
    output logic                 sync_err,
    output logic                 locked,
    output logic [SEL_WIDTH-1:0] sel
);

    localparam int unsigned SHADOW_W = CHANNELS - 1;
    localparam logic [SEL_WIDTH-1:0] SLOT_FIRST = '0;
    localparam logic [SEL_WIDTH-1:0] SLOT_ONE   = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SLOT_LAST  = SEL_WIDTH'(CHANNELS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [SEL_WIDTH-1:0]  slot;
    logic [SEL_WIDTH-1:0]  slot_nxt;
    logic [SHADOW_W-1:0]   shadow;
    logic [SHADOW_W-1:0]   shadow_nxt;
    logic [CHANNELS-1:0]   y_nxt;
    logic                  frame_valid_nxt;
    logic                  sync_err_nxt;

    // Slot classification of the current sample.
    logic at_first;
    logic at_last;

    assign at_first = (slot == SLOT_FIRST);
    assign at_last  = (slot == SLOT_LAST);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: lock on sync, drop lock only on a missing slot-0 sync.
    always_comb begin
        state_nxt = state;
        if (en) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (at_first && !sync) begin
                        state_nxt = HUNT;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Datapath/output next values: slot advance, shadow capture, frame commit.
    always_comb begin
        slot_nxt        = slot;
        shadow_nxt      = shadow;
        y_nxt           = y;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        if (en) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        shadow_nxt[0] = d;
                        slot_nxt      = SLOT_ONE;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Sync anywhere but slot 0 drops the partial frame and restarts.
                        sync_err_nxt  = !at_first;
                        shadow_nxt[0] = d;
                        slot_nxt      = SLOT_ONE;
                    end else if (at_first) begin
                        // Missing sync: discard sample and fall back to hunting.
                        sync_err_nxt = 1'b1;
                        slot_nxt     = SLOT_FIRST;
                    end else if (at_last) begin
                        // Last slot goes straight into y so the word updates atomically.
                        y_nxt           = {d, shadow};
                        frame_valid_nxt = 1'b1;
                        slot_nxt        = SLOT_FIRST;
                    end else begin
                        for (int unsigned i = 0; i < SHADOW_W; i++) begin
                            if (slot == SEL_WIDTH'(i)) begin
                                shadow_nxt[i] = d;
                            end
                        end
                        slot_nxt = slot + SLOT_ONE;
                    end
                end
                default: begin
                    slot_nxt = SLOT_FIRST;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot        <= SLOT_FIRST;
            shadow      <= '0;
            y           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            slot        <= slot_nxt;
            shadow      <= shadow_nxt;
            y           <= y_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
            locked      <= (state_nxt == LOCKED);
        end
    end

    assign sel = slot;

endmodule

// File: tb/tb_cy_tdm_demux8.sv
// Self-checking bench for cy_tdm_demux8: directed scenarios plus random
// framed traffic with injected sync faults, checked against a queue model.
module tb_cy_tdm_demux8;

    localparam int unsigned CHANNELS  = 8;
    localparam int unsigned SEL_WIDTH = 3;

    logic                 clock;
    logic                 reset;
    logic                 en;
    logic                 d;
    logic                 sync;
    logic [CHANNELS-1:0]  y;
    logic                 frame_valid;
    logic                 sync_err;
    logic                 locked;
    logic [SEL_WIDTH-1:0] sel;

    int n_vec;
    int n_err;

    // Reference model: bits of the frame collected so far, in slot order.
    bit                  m_q[$];
    bit                  m_locked;
    logic [CHANNELS-1:0] m_y;
    bit                  m_fv;
    bit                  m_err;

    cy_tdm_demux8 #(
        .CHANNELS (CHANNELS),
        .SEL_WIDTH(SEL_WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .d          (d),
        .sync       (sync),
        .y          (y),
        .frame_valid(frame_valid),
        .sync_err   (sync_err),
        .locked     (locked),
        .sel        (sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_locked = 1'b0;
        m_y      = '0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
    endtask

    // Framing rules applied to one clock's inputs.
    task automatic model_step(input bit e, input bit s, input bit b);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!e) return;
        if (!m_locked) begin
            if (s) begin
                m_q.delete();
                m_q.push_back(b);
                m_locked = 1'b1;
            end
        end else if (s) begin
            if (m_q.size() != 0) m_err = 1'b1;
            m_q.delete();
            m_q.push_back(b);
        end else if (m_q.size() == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_q.push_back(b);
            if (m_q.size() == CHANNELS) begin
                for (int k = 0; k < int'(CHANNELS); k++) m_y[k] = m_q[k];
                m_fv = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y"},     32'(y),           32'(m_y));
        check({tag, ".fv"},    32'(frame_valid), 32'(m_fv));
        check({tag, ".err"},   32'(sync_err),    32'(m_err));
        check({tag, ".lock"},  32'(locked),      32'(m_locked));
        check({tag, ".sel"},   32'(sel),         32'(m_q.size()));
    endtask

    // Drive one cycle, advance the model, compare just after the edge.
    task automatic step(input string tag, input bit e, input bit s, input bit b);
        en   = e;
        sync = s;
        d    = b;
        model_step(e, s, b);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, ".y"},    32'(y),      32'h0);
        check({tag, ".sel"},  32'(sel),    32'h0);
        check({tag, ".lock"}, 32'(locked), 32'h0);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [CHANNELS-1:0] val, input bit gaps);
        for (int k = 0; k < int'(CHANNELS); k++) begin
            step(tag, 1'b1, (k == 0), val[k]);
            if (gaps) step({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
        end
    endtask

    int fv_seen;

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        reset = 1'b1;
        en    = 1'b0;
        d     = 1'b0;
        sync  = 1'b0;
        #12;
        check_all("rst");
        reset = 1'b0;

        // 1: one clean frame 0x4D.
        send_frame("t1", 8'h4D, 1'b0);
        check("t1.y_const", 32'(y), 32'h4D);
        check("t1.sel0", 32'(sel), 32'h0);

        // 2: same frame with idle cycles between samples.
        async_reset("t2.rst");
        send_frame("t2", 8'h4D, 1'b1);
        check("t2.y_const", 32'(y), 32'h4D);

        // 3: no sync ever -> stays hunting.
        async_reset("t3.rst");
        fv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step("t3", 1'b1, 1'b0, 1'($urandom));
            fv_seen += int'(frame_valid) + int'(sync_err);
        end
        check("t3.pulses", 32'(fv_seen), 32'h0);
        check("t3.y_const", 32'(y), 32'h0);

        // 4: early sync at slot 3 after a good frame.
        send_frame("t4a", 8'h4D, 1'b0);
        step("t4b", 1'b1, 1'b1, 1'b0);
        step("t4b", 1'b1, 1'b0, 1'b1);
        step("t4b", 1'b1, 1'b0, 1'b1);
        step("t4e", 1'b1, 1'b1, 1'b1);
        check("t4.err_const", 32'(sync_err), 32'h1);
        check("t4.y_hold", 32'(y), 32'h4D);
        check("t4.sel1", 32'(sel), 32'h1);
        for (int k = 1; k < int'(CHANNELS); k++) step("t4c", 1'b1, 1'b0, 1'(k & 1));
        check("t4.y_new", 32'(y), 32'hAB);

        // 5: missing sync at slot 0, then relock.
        step("t5", 1'b1, 1'b0, 1'b1);
        check("t5.err_const", 32'(sync_err), 32'h1);
        check("t5.unlock", 32'(locked), 32'h0);
        step("t5", 1'b1, 1'b0, 1'b0);
        send_frame("t5r", 8'h96, 1'b0);
        check("t5.y_new", 32'(y), 32'h96);

        // 6: async reset mid-frame at slot 5.
        for (int k = 0; k < 5; k++) step("t6", 1'b1, (k == 0), 1'b1);
        check("t6.sel5", 32'(sel), 32'h5);
        async_reset("t6.rst");

        // Random traffic: mostly well-framed, with sparse sync faults and resets.
        for (int i = 0; i < 4000; i++) begin
            bit e, s;
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) s = 1'($urandom);
            else s = (m_q.size() == 0);
            if ($urandom_range(0, 499) == 0) async_reset("rnd.rst");
            else step("rnd", e, s, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
